// File: rtl/capture_trigger_seq.sv
// Logic-analyzer capture engine: multi-stage sequential trigger (pattern, edge, occurrence)
// driving a circular pre/post-trigger trace buffer write port.
module capture_trigger_seq #(
    parameter int SAMPLE_WIDTH = 32,
    parameter int NUM_STAGES   = 4,
    parameter int ADDR_WIDTH   = 12,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [SAMPLE_WIDTH-1:0] i_sample_data,
    input  logic                    i_sample_valid,
    input  logic                    i_cfg_wr,
    input  logic [7:0]              i_cfg_addr,
    input  logic [31:0]             i_cfg_data,
    input  logic                    i_start,
    input  logic                    i_abort,
    output logic                    o_wr_en,
    output logic [ADDR_WIDTH-1:0]   o_wr_addr,
    output logic [SAMPLE_WIDTH-1:0] o_wr_data,
    output logic                    o_wr_is_trig,
    output logic [2:0]              o_state,
    output logic [2:0]              o_stage_idx,
    output logic                    o_done,
    output logic                    o_aborted,
    output logic [ADDR_WIDTH-1:0]   o_trig_addr,
    output logic [ADDR_WIDTH-1:0]   o_start_addr,
    output logic [ADDR_WIDTH:0]     o_trace_len
);
    typedef enum logic [2:0] {S_IDLE = 3'd0, S_ARMING = 3'd1, S_WAIT = 3'd2,
                              S_POST = 3'd3, S_DONE = 3'd4} state_t;

    localparam logic [31:0]           MAX_PRE  = 32'(2**ADDR_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    state_t                  r_state;
    logic [SAMPLE_WIDTH-1:0] r_care [NUM_STAGES];
    logic [SAMPLE_WIDTH-1:0] r_val  [NUM_STAGES];
    logic                    r_een  [NUM_STAGES];
    logic                    r_erise[NUM_STAGES];
    logic [7:0]              r_ech  [NUM_STAGES];
    logic [CNT_WIDTH-1:0]    r_occ  [NUM_STAGES];
    logic [ADDR_WIDTH-1:0]   r_pre, r_post;
    logic [SAMPLE_WIDTH-1:0] r_amask;
    logic [3:0]              r_used;

    logic [ADDR_WIDTH-1:0]   r_addr, r_cnt, r_wr_addr, r_trig_addr, r_start_addr;
    logic [ADDR_WIDTH:0]     r_trace_len;
    logic [SAMPLE_WIDTH-1:0] r_prev, r_wr_data;
    logic                    r_prev_valid, r_wr_en, r_wr_is_trig, r_done, r_aborted;
    logic [CNT_WIDTH-1:0]    r_occ_cnt;
    logic [2:0]              r_stage_idx;

    logic [SAMPLE_WIDTH-1:0] w_care, w_val, w_sel;
    logic                    w_een, w_erise, w_cur_bit, w_prev_bit, w_edge_ok, w_pat_ok;
    logic                    w_match, w_occ_hit, w_last, w_trig, w_cfg_ok, w_idle_or_done;
    logic [7:0]              w_ech;
    logic [CNT_WIDTH-1:0]    w_occ;
    logic [CNT_WIDTH:0]      w_occ_next, w_occ_need;
    logic [ADDR_WIDTH-1:0]   w_room, w_post_lim, w_cnt_nx;

    always_comb begin
        w_care  = '0;
        w_val   = '0;
        w_een   = 1'b0;
        w_erise = 1'b0;
        w_ech   = '0;
        w_occ   = '0;
        for (int s = 0; s < NUM_STAGES; s++) begin
            if (r_stage_idx == 3'(s)) begin
                w_care  = r_care[s];
                w_val   = r_val[s];
                w_een   = r_een[s];
                w_erise = r_erise[s];
                w_ech   = r_ech[s];
                w_occ   = r_occ[s];
            end
        end
    end

    // An edge channel beyond the sample width shifts the select to zero, so it can never match.
    assign w_sel      = SAMPLE_WIDTH'(1) << w_ech;
    assign w_cur_bit  = |(i_sample_data & w_sel);
    assign w_prev_bit = |(r_prev & w_sel);
    assign w_edge_ok  = !w_een || (r_prev_valid && (|w_sel) &&
                                   (w_cur_bit != w_prev_bit) && (w_cur_bit == w_erise));
    assign w_pat_ok   = ((i_sample_data ^ w_val) & w_care) == '0;
    assign w_match    = w_pat_ok && w_edge_ok;
    assign w_occ_next = {1'b0, r_occ_cnt} + {{CNT_WIDTH{1'b0}}, 1'b1};
    assign w_occ_need = (w_occ == '0) ? {{CNT_WIDTH{1'b0}}, 1'b1} : {1'b0, w_occ};
    assign w_occ_hit  = w_occ_next >= w_occ_need;
    assign w_last     = ({1'b0, r_stage_idx} + 4'd1) == r_used;
    assign w_trig     = (r_used == 4'd0) || (w_match && w_occ_hit && w_last);

    assign w_room     = ADDR_MAX - r_pre;
    assign w_post_lim = (r_post < w_room) ? r_post : w_room;
    assign w_cnt_nx   = r_cnt + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    assign w_idle_or_done = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_cfg_ok       = i_cfg_wr && w_idle_or_done;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                r_care[s]  <= '0;
                r_val[s]   <= '0;
                r_een[s]   <= 1'b0;
                r_erise[s] <= 1'b0;
                r_ech[s]   <= '0;
                r_occ[s]   <= '0;
            end
            r_pre   <= '0;
            r_post  <= '0;
            r_amask <= '1;
            r_used  <= '0;
        end else if (w_cfg_ok) begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                if (i_cfg_addr[7:2] == 6'(s)) begin
                    case (i_cfg_addr[1:0])
                        2'd0: r_care[s] <= i_cfg_data[SAMPLE_WIDTH-1:0];
                        2'd1: r_val[s]  <= i_cfg_data[SAMPLE_WIDTH-1:0];
                        2'd2: begin
                            r_een[s]   <= i_cfg_data[9];
                            r_erise[s] <= i_cfg_data[8];
                            r_ech[s]   <= i_cfg_data[7:0];
                        end
                        default: r_occ[s] <= i_cfg_data[CNT_WIDTH-1:0];
                    endcase
                end
            end
            case (i_cfg_addr)
                8'h40: r_pre   <= (i_cfg_data > MAX_PRE) ? ADDR_MAX : i_cfg_data[ADDR_WIDTH-1:0];
                8'h41: r_post  <= (i_cfg_data > MAX_PRE) ? ADDR_MAX : i_cfg_data[ADDR_WIDTH-1:0];
                8'h42: r_amask <= i_cfg_data[SAMPLE_WIDTH-1:0];
                8'h43: r_used  <= (i_cfg_data > 32'(NUM_STAGES)) ? 4'(NUM_STAGES) : i_cfg_data[3:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_cnt        <= '0;
            r_occ_cnt    <= '0;
            r_stage_idx  <= '0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_wr_is_trig <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_trig_addr  <= '0;
            r_start_addr <= '0;
            r_trace_len  <= '0;
        end else begin
            r_wr_en      <= 1'b0;
            r_wr_is_trig <= 1'b0;
            if (i_abort) begin
                r_state   <= S_IDLE;
                r_aborted <= 1'b1;
                r_done    <= 1'b0;
            end else if (i_start && w_idle_or_done) begin
                r_state      <= (r_pre == '0) ? S_WAIT : S_ARMING;
                r_addr       <= '0;
                r_cnt        <= '0;
                r_occ_cnt    <= '0;
                r_stage_idx  <= '0;
                r_prev_valid <= 1'b0;
                r_aborted    <= 1'b0;
                r_done       <= 1'b0;
            end else if (i_sample_valid && !w_idle_or_done && r_state != S_IDLE) begin
                r_wr_en      <= 1'b1;
                r_wr_addr    <= r_addr;
                r_wr_data    <= i_sample_data & r_amask;
                r_addr       <= r_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                r_prev       <= i_sample_data;
                r_prev_valid <= 1'b1;
                case (r_state)
                    S_ARMING: begin
                        r_cnt <= w_cnt_nx;
                        if (w_cnt_nx == r_pre) begin
                            r_state <= S_WAIT;
                            r_cnt   <= '0;
                        end
                    end
                    S_WAIT: begin
                        if (w_trig) begin
                            r_wr_is_trig <= 1'b1;
                            r_trig_addr  <= r_addr;
                            r_occ_cnt    <= '0;
                            r_cnt        <= '0;
                            if (w_post_lim == '0) begin
                                r_state      <= S_DONE;
                                r_done       <= 1'b1;
                                r_start_addr <= r_addr - r_pre;
                                r_trace_len  <= {1'b0, r_pre} + {{ADDR_WIDTH{1'b0}}, 1'b1};
                            end else begin
                                r_state <= S_POST;
                            end
                        end else if (w_match) begin
                            if (w_occ_hit) begin
                                r_occ_cnt   <= '0;
                                r_stage_idx <= r_stage_idx + 3'd1;
                            end else begin
                                r_occ_cnt <= w_occ_next[CNT_WIDTH-1:0];
                            end
                        end
                    end
                    S_POST: begin
                        r_cnt <= w_cnt_nx;
                        if (w_cnt_nx == w_post_lim) begin
                            r_state      <= S_DONE;
                            r_done       <= 1'b1;
                            r_start_addr <= r_trig_addr - r_pre;
                            r_trace_len  <= {1'b0, r_pre} + {1'b0, w_cnt_nx} +
                                            {{ADDR_WIDTH{1'b0}}, 1'b1};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_wr_en      = r_wr_en;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;
    assign o_wr_is_trig = r_wr_is_trig;
    assign o_state      = r_state;
    assign o_stage_idx  = r_stage_idx;
    assign o_done       = r_done;
    assign o_aborted    = r_aborted;
    assign o_trig_addr  = r_trig_addr;
    assign o_start_addr = r_start_addr;
    assign o_trace_len  = r_trace_len;
endmodule

// File: doc/capture_trigger_seq.md
Name: capture_trigger_seq

Overview:
- Next-generation capture engine for the logic analyzer.
- Sample width is parametrised, with a multi-stage sequential trigger (pattern plus edge plus occurrence count per stage) and a circular pre-trigger/post-trigger buffer address generator.
- Sits between the synchronised sample bus and the trace memory write port.
- Configured by the command/register layer through a word-wide config bus; reports status and trace boundaries back to it.

Parameters:
SAMPLE_WIDTH, 32, sample bits (1..32)
NUM_STAGES, 4, trigger stages implemented (1..8)
ADDR_WIDTH, 12, buffer address bits; DEPTH = 2**ADDR_WIDTH
CNT_WIDTH, 16, occurrence counter width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sample_data  in  SAMPLE_WIDTH  synchronised sample
sample_valid  in  1  qualifies sample_data
cfg_wr  in  1  config write strobe
cfg_addr  in  8  config register index
cfg_data  in  32  config write data
start  in  1  single-cycle arm pulse
abort  in  1  single-cycle abort pulse
wr_en  out  1  trace memory write
wr_addr  out  ADDR_WIDTH  circular write address
wr_data  out  SAMPLE_WIDTH  sample AND active_mask
wr_is_trig  out  1  marks the trigger sample
state  out  3  IDLE=0, ARMING=1, WAIT_TRIG=2, POST=3, DONE=4
stage_idx  out  3  current trigger stage
done  out  1  level, high in DONE
aborted  out  1  level, set by abort, cleared by start
trig_addr  out  ADDR_WIDTH  address of trigger sample
start_addr  out  ADDR_WIDTH  first valid trace address
trace_len  out  ADDR_WIDTH+1  samples in trace

Behaviour:

Reset:
- All outputs 0.
- Config registers: masks 0, values 0, occurrence 0, pre 0, post 0, active_mask all-ones, stages_used 0.

Config map (32-bit words, fields LSB-aligned):
- Stage s at 4s+0: care mask; 4s+1: pattern value; 4s+2: {edge_en[9], edge_rise[8], edge_ch[7:0]}; 4s+3: occurrence count.
- 0x40: pre_count; 0x41: post_count; 0x42: active_mask; 0x43: stages_used (clamped to NUM_STAGES).
- Unmapped addresses and stage s >= NUM_STAGES are ignored.
- Writes take effect only in IDLE or DONE; otherwise they are dropped.
- pre_count is clamped to DEPTH-1 on write.

Stage match (combinational on an accepted sample):
- Pattern: ((sample ^ value) & care) == 0.
- Edge (if edge_en): prev[ch] != cur[ch], and cur[ch] == edge_rise.
- An edge needs prev_valid, which is cleared on start, so the first sample after start never edges.
- Match = pattern AND edge.
- edge_ch >= SAMPLE_WIDTH never matches when edge_en is set.

Occurrence handling:
- Each match increments occ_cnt.
- The stage advances when occ_cnt+1 >= max(occ,1); occ_cnt then clears.
- The final stage advancing is the trigger.
- stages_used = 0 triggers on the first sample eligible in WAIT_TRIG.

FSM (transitions on accepted samples unless noted):
- IDLE --start--> ARMING. wr_addr=0, counters cleared, aborted cleared.
- ARMING: write each sample. Go to WAIT_TRIG after pre_count samples written; immediately on the start cycle if pre_count = 0. Triggers are not evaluated in ARMING.
- WAIT_TRIG: write each sample, evaluate the current stage. On trigger, that sample is written with wr_is_trig=1, trig_addr is latched, and the FSM goes to POST (or DONE if the post limit is 0).
- POST: write samples until post_written == min(post_count, DEPTH-1-pre_count), then go to DONE.
- DONE:
  - start_addr = trig_addr - pre_count mod DEPTH.
  - trace_len = pre_count + 1 + post_written.
  - Next start re-arms.
- start outside IDLE/DONE is ignored.
- abort in any state returns to IDLE next cycle: aborted=1, done=0, wr_en=0.
- abort and start in the same cycle: abort wins.
- sample_valid=0 leaves all counters and the FSM unchanged.

Write timing:
- wr_en/wr_addr/wr_data/wr_is_trig are registered one cycle after the accepted sample.
- wr_addr increments mod DEPTH after each write; it wraps freely during WAIT_TRIG.

Test Plan:
1. pre=4, post=3, stages_used=1, care=0xFF, value=0x5A; samples 0..9, then 0x5A at the 11th sample -> trig_addr=10, start_addr=6, trace_len=8, done=1, exactly one wr_is_trig.
2. Two stages: stage0 pattern 0x01 with occ=3; stage1 rising edge ch4 -> no trigger until the third 0x01 match, then trigger on the next 0->1 of bit 4; stage_idx goes 0->1.
3. ADDR_WIDTH=4, pre=3, post=20, trigger after 40 samples -> wr_addr wraps; post truncated to 12, trace_len=16, start_addr=trig_addr-3 mod 16.
4. abort asserted mid-POST together with start -> state=IDLE next cycle, aborted=1, done=0, no further wr_en.
5. Config write to 0x40 during WAIT_TRIG -> pre_count unchanged; the same write in DONE takes effect; pre=0xFFFF clamps to DEPTH-1.
6. stages_used=0, pre=0 -> trigger on the first accepted sample after start; sample_valid gaps hold all state.
